// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO: captures core retirements, show-ahead valid/ready out.
// Optional TRACE_FILTER_ZERO_EN drops register writes to $0 before the FIFO.
module commit_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc_now,
  input  logic [31:0]              addr_now,
  input  logic [31:0]              str_now,
  input  logic                     if_reg,
  input  logic                     if_mem,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_kind,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  rec_t             mem_q [DEPTH];
  rec_t             rec_w;
  rec_t             head;
  logic [PW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       kind_w;
  logic             push, pop, full;
  logic             accept, drop;

`ifdef TRACE_FILTER_ZERO_EN
  assign kind_w = {if_mem, if_reg & (addr_now[4:0] != 5'd0)};
`else
  assign kind_w = {if_mem, if_reg};
`endif

  always_comb begin
    rec_w      = '0;
    rec_w.kind = kind_w;
    rec_w.pc   = pc_now;
    rec_w.data = str_now;
    rec_w.addr = addr_now;
    if (kind_w == 2'b01)
      rec_w.addr = {27'd0, addr_now[4:0]};
  end

  assign push   = |kind_w;
  assign pop    = (level_q != '0) & out_ready;
  assign full   = (level_q == LW'(DEPTH));
  assign accept = push & (~full | pop);
  assign drop   = push & ~accept;

  assign level_d = level_q + LW'(accept) - LW'(pop);

  // A drop coinciding with a clear counts as the first drop after it.
  always_comb begin
    ovf_d = ovf_q | drop;
    cnt_d = cnt_q;
    if (clr_ovf) begin
      ovf_d = drop;
      cnt_d = CNT_W'(drop);
    end else if (drop && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop)    rd_q <= rd_q + 1'b1;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= rec_w;
  end

  assign head      = mem_q[rd_q];
  assign out_valid = (level_q != '0);
  assign out_kind  = out_valid ? head.kind : 2'b00;
  assign out_pc    = out_valid ? head.pc   : 32'd0;
  assign out_addr  = out_valid ? head.addr : 32'd0;
  assign out_data  = out_valid ? head.data : 32'd0;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized bench for commit_trace_buffer against a queue-based model.
// Honours TRACE_FILTER_ZERO_EN the same way the design does.
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_now, addr_now, str_now;
  logic        if_reg, if_mem;
  logic        out_valid, out_ready;
  logic [1:0]  out_kind;
  logic [31:0] out_pc, out_addr, out_data;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clr_ovf;

  commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .pc_now(pc_now), .addr_now(addr_now), .str_now(str_now),
    .if_reg(if_reg), .if_mem(if_mem),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_pc(out_pc),
    .out_addr(out_addr), .out_data(out_data),
    .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] d;
  } rec_t;

  rec_t q[$];
  logic m_ovf;
  int   m_cnt;
  int   n_chk = 0;
  int   n_fail = 0;

  logic        hold;
  logic [1:0]  p_kind;
  logic [31:0] p_pc, p_addr, p_data;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
    hold  = 1'b0;
  endtask

  task automatic check_outputs();
    rec_t h;
    h = (q.size() > 0) ? q[0] : '0;
    check("valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    check("kind", {30'd0, out_kind}, {30'd0, h.k});
    check("pc", out_pc, h.pc);
    check("addr", out_addr, h.a);
    check("data", out_data, h.d);
    check("level", {27'd0, level}, q.size());
    check("ovf", {31'd0, overflow}, {31'd0, m_ovf});
    check("dropcnt", {16'd0, drop_cnt}, m_cnt);
    if (hold) begin
      check("stab_kind", {30'd0, out_kind}, {30'd0, p_kind});
      check("stab_pc", out_pc, p_pc);
      check("stab_addr", out_addr, p_addr);
      check("stab_data", out_data, p_data);
    end
    hold   = out_valid & ~out_ready;
    p_kind = out_kind;
    p_pc   = out_pc;
    p_addr = out_addr;
    p_data = out_data;
  endtask

  task automatic model_edge();
    rec_t r;
    logic pop, was_full, drop;
    logic [1:0] k;
    k = {if_mem, if_reg};
`ifdef TRACE_FILTER_ZERO_EN
    if (addr_now[4:0] == 5'd0) k[0] = 1'b0;
`endif
    pop      = (q.size() > 0) && out_ready;
    was_full = (q.size() == DEPTH);
    drop     = 1'b0;
    if (pop) void'(q.pop_front());
    if (k != 2'b00) begin
      r.k  = k;
      r.pc = pc_now;
      r.d  = str_now;
      r.a  = (k == 2'b01) ? (addr_now % 32) : addr_now;
      if (!was_full || pop) q.push_back(r);
      else drop = 1'b1;
    end
    if (clr_ovf) begin
      m_ovf = drop;
      m_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic step(input logic r, input logic m, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic rdy, input logic clr);
    if_reg    = r;
    if_mem    = m;
    pc_now    = pc;
    addr_now  = a;
    str_now   = d;
    out_ready = rdy;
    clr_ovf   = clr;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    if_reg = 0; if_mem = 0; pc_now = 0; addr_now = 0; str_now = 0;
    out_ready = 0; clr_ovf = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    idle(1'b0);
    check("rst_level", {27'd0, level}, 32'd0);

    step(1'b1, 1'b0, 32'h3000, 32'd8, 32'h1234, 1'b0, 1'b0);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_kind", {30'd0, out_kind}, 32'd1);
    check("single_addr", out_addr, 32'd8);
    check("single_data", out_data, 32'h1234);
    idle(1'b1);
    check("single_drain", {27'd0, level}, 32'd0);

    repeat (3) begin
      for (int i = 0; i < 16; i++)
        step(1'b0, 1'b1, 32'h3000 + 4 * i, 32'h100 + i, i, 1'b0, 1'b0);
      check("wrap_full", {27'd0, level}, 32'd16);
      for (int i = 0; i < 16; i++) begin
        check("wrap_pc", out_pc, 32'h3000 + 4 * i);
        idle(1'b1);
      end
      check("wrap_empty", {27'd0, level}, 32'd0);
    end

    for (int i = 0; i < 18; i++)
      step(1'b0, 1'b1, 32'h4000 + 4 * i, 32'h200, i, 1'b0, 1'b0);
    check("ovf_level", {27'd0, level}, 32'd16);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_cnt", {16'd0, drop_cnt}, 32'd2);
    step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    check("clr_flag", {31'd0, overflow}, 32'd0);
    check("clr_cnt", {16'd0, drop_cnt}, 32'd0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'h5000 + 4 * i, 32'h300, i, 1'b1, 1'b0);
    check("fullpp_level", {27'd0, level}, 32'd16);
    check("fullpp_ovf", {31'd0, overflow}, 32'd0);

    step(1'b1, 1'b1, 32'h6000, 32'h40, 32'h77, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h6004, 32'h44, 32'h78, 1'b0, 1'b1);
    check("clrdrop_flag", {31'd0, overflow}, 32'd1);
    check("clrdrop_cnt", {16'd0, drop_cnt}, 32'd1);

    for (int i = 0; i < 11; i++) idle(1'b1);
    check("pre_rst_level", {27'd0, level}, 32'd5);
    #2 reset = 1'b1;
    #1;
    check("arst_level", {27'd0, level}, 32'd0);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_ovf", {31'd0, overflow}, 32'd0);
    model_reset();
    if_reg = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    if_reg = 1'b0;
    idle(1'b0);

    step(1'b1, 1'b0, 32'h7000, 32'h0, 32'h55, 1'b0, 1'b0);
`ifdef TRACE_FILTER_ZERO_EN
    check("filt_level", {27'd0, level}, 32'd0);
`else
    check("filt_level", {27'd0, level}, 32'd1);
    check("filt_addr", out_addr, 32'd0);
`endif
    while (q.size() > 0) idle(1'b1);
    step(1'b1, 1'b1, 32'h7004, 32'h0, 32'h66, 1'b0, 1'b0);
`ifdef TRACE_FILTER_ZERO_EN
    check("filt_both", {30'd0, out_kind}, 32'd2);
`else
    check("filt_both", {30'd0, out_kind}, 32'd3);
`endif
    while (q.size() > 0) idle(1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [1:0]  f;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[4:0] = 5'd0;
      f = ($urandom_range(0, 9) < 6) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(f[0], f[1], $urandom, a, $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
    end
    while (q.size() > 0) idle(1'b1);
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
